line_memory: RTL and testbench
==============================

// Module: line_memory
// PURPOSE
//  Parametrised multi-cycle main memory behind the cache/datapath. Serves line reads
//  (LINE_WORDS words from the line-aligned base) and single-word writes.
//  Latency is programmable; completion is a one-cycle pulse and busy gives back-pressure.
//  Replaces the fixed 4-word, free-running-counter memory with an explicit FSM.
// PARAMETERS
//  ADDR_WIDTH    10    word-address width; DEPTH = 2**ADDR_WIDTH words
//  DATA_WIDTH    32    word width (multiple of 8)
//  LINE_WORDS    4     words per read line; power of 2, >=1, <= DEPTH
//  READ_LATENCY  3     cycles from read accept to ready_to_read pulse; >=1
//  WRITE_LATENCY 3     cycles from write accept to finished_writing pulse; >=1
// PORTS
//  clk              in   1                      rising-edge clock
//  rst_n            in   1                      asynchronous, active-low reset
//  mem_read         in   1                      read request (line), sampled in IDLE only
//  mem_write        in   1                      write request (word), sampled in IDLE only
//  add              in   ADDR_WIDTH             word address
//  write_data       in   DATA_WIDTH             write word
//  byte_en          in   DATA_WIDTH/8           byte strobes (only with LINE_MEM_BYTE_EN_EN)
//  busy             out  1                      high while a request is in flight
//  read_data        out  LINE_WORDS*DATA_WIDTH  line; word i at bits [i*DW +: DW]
//  ready_to_read    out  1                      1-cycle pulse: read_data valid
//  finished_writing out  1                      1-cycle pulse: write committed
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, busy=0, read_data=0, ready_to_read=0,
//    finished_writing=0, latency counter=0. Memory array is NOT cleared.
//  - States: IDLE, RD_WAIT, WR_WAIT.
//  - IDLE: at a clock edge with mem_write=1, latch add/write_data(/byte_en) -> WR_WAIT.
//    Else with mem_read=1, latch base = {add[AW-1:log2(LINE_WORDS)], 0s} -> RD_WAIT.
//    Write wins when both are high; the read is dropped (requester must re-issue).
//  - Accepting edge: counter loads the LATENCY; busy=1 from the following cycle.
//  - RD_WAIT/WR_WAIT: counter decrements each edge. On the edge where it reaches 0:
//    read: read_data[i] <= mem[base+i] for i=0..LINE_WORDS-1, ready_to_read=1.
//    write: mem[addr] <= write_data, finished_writing=1.
//    Same edge: state -> IDLE, busy -> 0.
//  - Result: pulse is visible exactly LATENCY cycles after the accepting edge. busy is
//    high for LATENCY cycles. Pulses drop next cycle. Back-to-back: a new request may
//    be accepted on the edge after the pulse cycle.
//  - read_data holds its value until the next read completes; writes never change it.
//  - Requests while busy are ignored, not queued. Inputs other than the latched
//    copies may change freely in flight.
//  - Write commits at completion only: read-after-write to the same line, issued
//    after finished_writing, returns the new data.
//  - Address wraps modulo DEPTH. Base is line-aligned, so a line never straddles the top.
//  - Reset mid-operation: request abandoned; an in-flight write is NOT committed;
//    no pulse is produced.
// CONFIGURATION
//  LINE_MEM_BYTE_EN_EN defined: byte_en port exists. On write commit, only bytes with
//    byte_en[b]=1 are updated; byte_en=0 still pulses finished_writing.
//  Not defined: no byte_en port; every write updates the full word.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, busy=0.
//  2 Write 0xDEADBEEF @ add=5 (WRITE_LATENCY=3) -> busy 3 cycles, finished_writing
//    pulses 3 cycles after accept. Then read add=7 -> line base 4; word1 = 0xDEADBEEF.
//  3 Simultaneous mem_read=mem_write=1 @ add=8 -> write taken, no ready_to_read pulse.
//  4 Request while busy -> ignored; exactly one pulse per accepted request.
//    Back-to-back reads at add=0 then add=1020 -> both complete; 2nd line is words 1020..1023.
//  5 rst_n=0 during WR_WAIT writing 0x1234 to add=9 -> later read shows old word 9, no pulse.
//  6 With LINE_MEM_BYTE_EN_EN: word=0xFFFFFFFF, write 0x00000000 with byte_en=4'b0101
//    -> reads back 0xFF00FF00.

Source files
------------

// File: rtl/line_memory_if.sv
// Request/response bundle between a requester (cache/datapath) and line_memory.
// byte_en exists only when LINE_MEM_BYTE_EN_EN is defined.
interface line_memory_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
);
    logic                             mem_read;
    logic                             mem_write;
    logic [ADDR_WIDTH-1:0]            add;
    logic [DATA_WIDTH-1:0]            write_data;
`ifdef LINE_MEM_BYTE_EN_EN
    logic [DATA_WIDTH/8-1:0]          byte_en;
`endif
    logic                             busy;
    logic [LINE_WORDS*DATA_WIDTH-1:0] read_data;
    logic                             ready_to_read;
    logic                             finished_writing;

`ifdef LINE_MEM_BYTE_EN_EN
    modport master (
        output mem_read, mem_write, add, write_data, byte_en,
        input  busy, read_data, ready_to_read, finished_writing
    );
    modport slave (
        input  mem_read, mem_write, add, write_data, byte_en,
        output busy, read_data, ready_to_read, finished_writing
    );
`else
    modport master (
        output mem_read, mem_write, add, write_data,
        input  busy, read_data, ready_to_read, finished_writing
    );
    modport slave (
        input  mem_read, mem_write, add, write_data,
        output busy, read_data, ready_to_read, finished_writing
    );
`endif
endinterface

// File: rtl/line_memory.sv
// Multi-cycle main memory: line reads, single-word writes, programmable latency.
// Optional byte strobes on writes are enabled by defining LINE_MEM_BYTE_EN_EN.
module line_memory #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int LINE_WORDS    = 4,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    line_memory_if.slave bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
    localparam int LAT_MAX   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W     = $clog2(LAT_MAX + 1);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]      RD_LOAD   = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0]      WR_LOAD   = CNT_W'(WRITE_LATENCY);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    busy_r, busy_s;
    logic                    rtr_r, rtr_s;
    logic                    fw_r, fw_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
    logic [LINE_BITS-1:0]    read_data_r;
    logic [LINE_BITS-1:0]    line_s;
    logic [DATA_WIDTH-1:0]   commit_word_s;
    logic                    rd_done_s;
    logic                    wr_done_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

`ifdef LINE_MEM_BYTE_EN_EN
    localparam int BYTES = DATA_WIDTH / 8;
    logic [BYTES-1:0]        be_r, be_s;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BYTES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

    // Next-state, latched request and completion pulses.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        busy_s    = busy_r;
        rtr_s     = 1'b0;
        fw_s      = 1'b0;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        rd_done_s = 1'b0;
        wr_done_s = 1'b0;
`ifdef LINE_MEM_BYTE_EN_EN
        be_s      = be_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // Write has priority; a simultaneous read is dropped.
                if (bus.mem_write) begin
                    addr_s  = bus.add;
                    wdata_s = bus.write_data;
`ifdef LINE_MEM_BYTE_EN_EN
                    be_s    = bus.byte_en;
`endif
                    cnt_s   = WR_LOAD;
                    busy_s  = 1'b1;
                    state_s = ST_WR_WAIT;
                end else if (bus.mem_read) begin
                    addr_s  = bus.add & LINE_MASK;
                    cnt_s   = RD_LOAD;
                    busy_s  = 1'b1;
                    state_s = ST_RD_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    rd_done_s = 1'b1;
                    rtr_s     = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    wr_done_s = 1'b1;
                    fw_s      = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_WR_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    // Gather the addressed line; base is aligned so base+i never wraps past the top.
    always_comb begin
        line_s = {LINE_BITS{1'b0}};
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_s[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[addr_r + ADDR_WIDTH'(i)];
        end
    end

    // Word written at commit time.
    always_comb begin
`ifdef LINE_MEM_BYTE_EN_EN
        commit_word_s = merge_bytes(mem_r[addr_r], wdata_r, be_r);
`else
        commit_word_s = wdata_r;
`endif
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            rtr_r       <= 1'b0;
            fw_r        <= 1'b0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            read_data_r <= {LINE_BITS{1'b0}};
`ifdef LINE_MEM_BYTE_EN_EN
            be_r        <= {BYTES{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            rtr_r   <= rtr_s;
            fw_r    <= fw_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
`ifdef LINE_MEM_BYTE_EN_EN
            be_r    <= be_s;
`endif
            if (rd_done_s) begin
                read_data_r <= line_s;
            end else begin
                read_data_r <= read_data_r;
            end
        end
    end

    // Storage array: deliberately not reset; commits only on write completion.
    always_ff @(posedge clk) begin
        if (wr_done_s) begin
            mem_r[addr_r] <= commit_word_s;
        end
    end

    assign bus.busy             = busy_r;
    assign bus.ready_to_read    = rtr_r;
    assign bus.finished_writing = fw_r;
    assign bus.read_data        = read_data_r;

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory: expected pulses/lines queued at issue, checked on output.
module tb_line_memory;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int RL  = 3;
    localparam int WL  = 3;
    localparam int LDW = LW * DW;

    typedef struct {
        logic [LDW-1:0] line;
        int             due;
    } rd_exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rd_seen = 0, wr_seen = 0, rd_issued = 0, wr_issued = 0;
    rd_exp_t        rdq[$];
    int             wrq[$];
    logic [DW-1:0]  model [1 << AW];
    logic [LDW-1:0] last_line;

    line_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) bus ();

    line_memory #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [LDW-1:0] obs, input logic [LDW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        int      due;
        if (bus.ready_to_read === 1'b1) begin
            rd_seen++;
            if (rdq.size() == 0) begin
                check_value("rd_unexpected_pulse", 1, 0);
            end else begin
                e = rdq.pop_front();
                check_value("rd_line", bus.read_data, e.line);
                check_value("rd_latency", cyc, e.due);
            end
        end
        if (bus.finished_writing === 1'b1) begin
            wr_seen++;
            if (wrq.size() == 0) begin
                check_value("wr_unexpected_pulse", 1, 0);
            end else begin
                due = wrq.pop_front();
                check_value("wr_latency", cyc, due);
            end
        end
    end

    task automatic idle_inputs();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // Called on the negedge where the request is driven; returns on the pulse-cycle negedge.
    task automatic run_busy(input int lat, input bit poke);
        @(negedge clk);
        idle_inputs();
        check_value("busy_start", bus.busy, 1);
        for (int j = 1; j < lat; j++) begin
            if (poke) begin
                bus.mem_read   = 1'b1;
                bus.mem_write  = 1'b1;
                bus.add        = 10'($urandom_range(1023));
                bus.write_data = $urandom;
            end
            @(negedge clk);
            check_value("busy_hold", bus.busy, 1);
        end
        idle_inputs();
        @(negedge clk);
        check_value("busy_end", bus.busy, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] be, input bit also_read, input bit poke);
        bus.add        = a;
        bus.write_data = d;
        bus.mem_write  = 1'b1;
        bus.mem_read   = also_read;
`ifdef LINE_MEM_BYTE_EN_EN
        bus.byte_en    = be;
        for (int b = 0; b < DW/8; b++) begin
            if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
`else
        if (be != '0) model[a] = d;
`endif
        wrq.push_back(cyc + 1 + WL);
        wr_issued++;
        run_busy(WL, poke);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit poke);
        rd_exp_t        e;
        logic [AW-1:0]  base;
        logic [AW-1:0]  mask;
        mask = ~AW'(LW - 1);
        base = a & mask;
        for (int i = 0; i < LW; i++) begin
            e.line[i*DW +: DW] = model[base + AW'(i)];
        end
        e.due = cyc + 1 + RL;
        rdq.push_back(e);
        rd_issued++;
        last_line     = e.line;
        bus.add       = a;
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b0;
        run_busy(RL, poke);
    endtask

    initial begin
        logic [LDW-1:0] held;
        rst_n          = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.add        = '0;
        bus.write_data = '0;
`ifdef LINE_MEM_BYTE_EN_EN
        bus.byte_en    = '0;
`endif
        repeat (2) @(negedge clk);
        check_value("rst_busy", bus.busy, 0);
        check_value("rst_rtr", bus.ready_to_read, 0);
        check_value("rst_fw", bus.finished_writing, 0);
        check_value("rst_read_data", bus.read_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Line 4..7 with 0xDEADBEEF at word 5, then read via add=7.
        for (int i = 4; i < 8; i++) begin
            do_write(AW'(i), (i == 5) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(i)), 4'hF, 1'b0, 1'b0);
        end
        do_read(10'd7, 1'b1);
        check_value("line4_word1", bus.read_data[63:32], 32'hDEADBEEF);
        held = bus.read_data;

        // Write wins over simultaneous read; read_data unaffected by writes.
        for (int i = 9; i < 12; i++) begin
            do_write(AW'(i), 32'h2000_0000 | 32'(i), 4'hF, 1'b0, 1'b1);
        end
        do_write(10'd8, 32'hA5A5_0008, 4'hF, 1'b1, 1'b0);
        check_value("rd_hold_after_writes", bus.read_data, held);
        do_read(10'd8, 1'b1);

        // Back-to-back reads at the bottom and top lines.
        for (int i = 0; i < 4; i++) begin
            do_write(AW'(i), 32'h3000_0000 | 32'(i), 4'hF, 1'b0, 1'b0);
            do_write(AW'(1020 + i), 32'h4000_0000 | 32'(i), 4'hF, 1'b0, 1'b0);
        end
        do_read(10'd0, 1'b0);
        do_read(10'd1020, 1'b0);
        check_value("top_word3", bus.read_data[127:96], 32'h4000_0003);
        do_read(10'd1023, 1'b1);

        // Random traffic over lines 16..31.
        for (int i = 16; i < 32; i++) begin
            do_write(AW'(i), $urandom, 4'hF, 1'b0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            do_write(10'(16 + $urandom_range(15)), $urandom, 4'hF, 1'($urandom_range(1)), 1'b1);
            do_read(10'(16 + $urandom_range(15)), 1'($urandom_range(1)));
        end

        // Reset during WR_WAIT: write of 0x1234 to word 9 must be abandoned.
        bus.add        = 10'd9;
        bus.write_data = 32'h0000_1234;
        bus.mem_write  = 1'b1;
`ifdef LINE_MEM_BYTE_EN_EN
        bus.byte_en    = 4'hF;
`endif
        @(negedge clk);
        idle_inputs();
        check_value("pre_rst_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_value("midrst_busy", bus.busy, 0);
        check_value("midrst_rtr", bus.ready_to_read, 0);
        check_value("midrst_fw", bus.finished_writing, 0);
        check_value("midrst_read_data", bus.read_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(10'd9, 1'b0);
        check_value("word9_old", bus.read_data[63:32], 32'h2000_0009);

`ifdef LINE_MEM_BYTE_EN_EN
        for (int i = 12; i < 16; i++) begin
            do_write(AW'(i), 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
        end
        do_write(10'd12, 32'h0000_0000, 4'b0101, 1'b0, 1'b0);
        do_write(10'd13, 32'h0000_0000, 4'b0000, 1'b0, 1'b0);
        do_read(10'd12, 1'b0);
        check_value("byte_en_word", bus.read_data[31:0], 32'hFF00FF00);
        check_value("byte_en_none", bus.read_data[63:32], 32'hFFFF_FFFF);
`endif

        repeat (10) @(negedge clk);
        check_value("rdq_drained", 32'(rdq.size()), 0);
        check_value("wrq_drained", 32'(wrq.size()), 0);
        check_value("rd_pulse_count", 32'(rd_seen), 32'(rd_issued));
        check_value("wr_pulse_count", 32'(wr_seen), 32'(wr_issued));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
